axi_lite_req_arbiter: RTL
=========================

AXI_LITE_REQ_ARBITER -- requirements
Module: axi_lite_req_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, SHALL select arbitration: 1 = round-robin, 0 = fixed priority (requester 0 wins).
REQ-002 axi_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 axi_resetn  input  1  SHALL be a synchronous, active-low reset.
REQ-004 reqN_valid  input  1  (N=0,1) SHALL be the command request, held high until reqN_done.
REQ-005 reqN_we  input  1  SHALL select the command type: 1 = write, 0 = read.
REQ-006 reqN_addr  input  32  SHALL carry the command address, stable while reqN_valid is high.
REQ-007 reqN_wdata  input  32  SHALL carry the write data, stable while reqN_valid is high.
REQ-008 reqN_wstrb  input  4  SHALL carry the write byte strobes, stable while reqN_valid is high.
REQ-009 reqN_done  output  1  SHALL pulse for one cycle when requester N's transaction completes.
REQ-010 reqN_rdata  output  32  SHALL hold the read data, valid with reqN_done.
REQ-011 reqN_resp  output  2  SHALL hold the AXI response code, valid with reqN_done.
REQ-012 Master port  outputs  SHALL be axi_awaddr[31:0], axi_awvalid, axi_wdata[31:0], axi_wstrb[3:0], axi_wvalid, axi_bready, axi_araddr[31:0], axi_arvalid, axi_rready.
REQ-013 Master port  inputs  SHALL be axi_awready, axi_wready, axi_bresp[1:0], axi_bvalid, axi_arready, axi_rdata[31:0], axi_rresp[1:0], axi_rvalid.
REQ-014 busy  output  1  SHALL be high in every FSM state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
REQ-016 IDLE SHALL select a winner when any reqN_valid is high and latch winner id plus its addr, wdata, wstrb and we.
REQ-017 On selection the FSM SHALL move to WR_ADDR_DATA if we=1, else to RD_ADDR.
REQ-018 The master valids SHALL assert in the first cycle after selection (one-cycle grant latency).
REQ-019 With RR_EN=1 and both valids high, the requester not granted last SHALL win; after reset requester 0 has priority.
REQ-020 With RR_EN=0 and both valids high, requester 0 SHALL always win.
REQ-021 WR_ADDR_DATA SHALL assert awvalid and wvalid together.
REQ-022 Each valid SHALL drop independently the cycle after its own ready handshake (AWREADY and WREADY in any order or together).
REQ-023 The FSM SHALL go to WR_RESP once both the AW and W handshakes are done.
REQ-024 WR_RESP SHALL hold bready high; on bvalid&&bready it SHALL capture bresp, pulse the winner's done next cycle, and return to IDLE.
REQ-025 RD_ADDR SHALL assert arvalid until arready, then move to RD_DATA.
REQ-026 RD_DATA SHALL hold rready high; on rvalid&&rready it SHALL capture rdata and rresp, pulse done next cycle, and return to IDLE.
REQ-027 Valids SHALL never drop before their handshake completes; address, data and strobe SHALL stay stable while valid is high.
REQ-028 Only one transaction SHALL be outstanding at a time; a new selection SHALL occur no earlier than the cycle done pulses.
REQ-029 The loser of arbitration SHALL keep waiting with no done pulse; its command SHALL be served next if still valid.
REQ-030 Requester deassertion of valid before done is illegal; the arbiter SHALL still complete the latched transaction and pulse done.
REQ-031 reqN_rdata and reqN_resp SHALL hold their last values until the next done for that requester.
REQ-032 A write SHALL leave reqN_rdata unchanged.

Reset
REQ-033 While axi_resetn is low at a clock edge, the FSM SHALL go to IDLE.
REQ-034 Reset SHALL drive all master valids, bready, rready, done, and busy to 0.
REQ-035 Reset SHALL drive rdata to 32'h0, resp to 2'b00, and the round-robin pointer to requester 0.
REQ-036 Reset mid-transaction SHALL abandon it without a done pulse.

Verification
REQ-037 Single write (req0 only, addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, slave readies after 2 cycles, bresp 00) -> exactly one AW/W handshake with these values, then req0_done one pulse with resp 00.
REQ-038 Write then read: req1 read of addr 0x10, slave rdata 0xDEADBEEF rresp 00 -> req1_done pulse with rdata 0xDEADBEEF and req0_done stays 0.
REQ-039 Both requesters valid continuously, RR_EN=1 -> grants alternate 0,1,0,1 over 4 transactions; RR_EN=0 -> req0 served repeatedly and req1 only after req0 drops.
REQ-040 Skewed readies (AWREADY 3 cycles before WREADY, then WREADY before AWREADY) -> each valid drops individually, one B handshake per write.
REQ-041 Backpressure with bvalid or rvalid delayed 5 cycles -> busy stays 1 and no done pulse until the handshake.
REQ-042 Error response (bresp 2'b10) -> done with resp 10.
REQ-043 Reset asserted in RD_DATA -> all outputs reach their reset values next cycle and no done pulse.

Source files
------------

// File: rtl/axi_lite_req_arbiter.sv
// Two-requester arbiter in front of a single AXI4-Lite master port.
// One transaction is in flight at a time; results return as a one-cycle done pulse.
module axi_lite_req_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        axi_clk,
    input  logic        axi_resetn,

    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_wstrb,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic [1:0]  req0_resp,

    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_wstrb,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic [1:0]  req1_resp,

    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready,

    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic        grant_r, grant_s;
    logic        rr_ptr_r, rr_ptr_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [3:0]  wstrb_r, wstrb_s;
    logic        awvalid_r, awvalid_s;
    logic        wvalid_r, wvalid_s;
    logic        bready_r, bready_s;
    logic        arvalid_r, arvalid_s;
    logic        rready_r, rready_s;
    logic        done0_r, done0_s;
    logic        done1_r, done1_s;
    logic [31:0] rdata0_r, rdata0_s;
    logic [31:0] rdata1_r, rdata1_s;
    logic [1:0]  resp0_r, resp0_s;
    logic [1:0]  resp1_r, resp1_s;
    logic        busy_r, busy_s;

    logic        win_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [3:0]  sel_wstrb_s;

    // Winner selection and command mux; rr_ptr_r names the requester owning priority on a tie.
    always_comb begin
        win_s = 1'b0;
        if (req0_valid && req1_valid) begin
            if (RR_EN != 0) begin
                win_s = rr_ptr_r;
            end else begin
                win_s = 1'b0;
            end
        end else if (req1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end

        if (win_s) begin
            sel_we_s    = req1_we;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
            sel_wstrb_s = req1_wstrb;
        end else begin
            sel_we_s    = req0_we;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
            sel_wstrb_s = req0_wstrb;
        end
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        rr_ptr_s  = rr_ptr_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        wstrb_s   = wstrb_r;
        awvalid_s = awvalid_r;
        wvalid_s  = wvalid_r;
        bready_s  = bready_r;
        arvalid_s = arvalid_r;
        rready_s  = rready_r;
        done0_s   = 1'b0;
        done1_s   = 1'b0;
        rdata0_s  = rdata0_r;
        rdata1_s  = rdata1_r;
        resp0_s   = resp0_r;
        resp1_s   = resp1_r;

        case (state_r)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_s  = win_s;
                    rr_ptr_s = ~win_s;
                    addr_s   = sel_addr_s;
                    wdata_s  = sel_wdata_s;
                    wstrb_s  = sel_wstrb_s;
                    if (sel_we_s) begin
                        state_s   = WR_ADDR_DATA;
                        awvalid_s = 1'b1;
                        wvalid_s  = 1'b1;
                    end else begin
                        state_s   = RD_ADDR;
                        arvalid_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; leave once both have handshaken.
                if (awvalid_r && axi_awready) begin
                    awvalid_s = 1'b0;
                end else begin
                    awvalid_s = awvalid_r;
                end
                if (wvalid_r && axi_wready) begin
                    wvalid_s = 1'b0;
                end else begin
                    wvalid_s = wvalid_r;
                end
                if (!awvalid_s && !wvalid_s) begin
                    state_s  = WR_RESP;
                    bready_s = 1'b1;
                end else begin
                    state_s = WR_ADDR_DATA;
                end
            end
            WR_RESP: begin
                if (axi_bvalid && bready_r) begin
                    state_s  = IDLE;
                    bready_s = 1'b0;
                    if (grant_r) begin
                        resp1_s = axi_bresp;
                        done1_s = 1'b1;
                    end else begin
                        resp0_s = axi_bresp;
                        done0_s = 1'b1;
                    end
                end else begin
                    state_s = WR_RESP;
                end
            end
            RD_ADDR: begin
                if (arvalid_r && axi_arready) begin
                    state_s   = RD_DATA;
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (axi_rvalid && rready_r) begin
                    state_s  = IDLE;
                    rready_s = 1'b0;
                    if (grant_r) begin
                        rdata1_s = axi_rdata;
                        resp1_s  = axi_rresp;
                        done1_s  = 1'b1;
                    end else begin
                        rdata0_s = axi_rdata;
                        resp0_s  = axi_rresp;
                        done0_s  = 1'b1;
                    end
                end else begin
                    state_s = RD_DATA;
                end
            end
            default: begin
                state_s   = IDLE;
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                bready_s  = 1'b0;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge axi_clk) begin
        if (!axi_resetn) begin
            state_r   <= IDLE;
            grant_r   <= 1'b0;
            rr_ptr_r  <= 1'b0;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'h0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            done0_r   <= 1'b0;
            done1_r   <= 1'b0;
            rdata0_r  <= 32'h0000_0000;
            rdata1_r  <= 32'h0000_0000;
            resp0_r   <= 2'b00;
            resp1_r   <= 2'b00;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            rr_ptr_r  <= rr_ptr_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            wstrb_r   <= wstrb_s;
            awvalid_r <= awvalid_s;
            wvalid_r  <= wvalid_s;
            bready_r  <= bready_s;
            arvalid_r <= arvalid_s;
            rready_r  <= rready_s;
            done0_r   <= done0_s;
            done1_r   <= done1_s;
            rdata0_r  <= rdata0_s;
            rdata1_r  <= rdata1_s;
            resp0_r   <= resp0_s;
            resp1_r   <= resp1_s;
            busy_r    <= busy_s;
        end
    end

    assign axi_awaddr  = addr_r;
    assign axi_awvalid = awvalid_r;
    assign axi_wdata   = wdata_r;
    assign axi_wstrb   = wstrb_r;
    assign axi_wvalid  = wvalid_r;
    assign axi_bready  = bready_r;
    assign axi_araddr  = addr_r;
    assign axi_arvalid = arvalid_r;
    assign axi_rready  = rready_r;
    assign req0_done   = done0_r;
    assign req0_rdata  = rdata0_r;
    assign req0_resp   = resp0_r;
    assign req1_done   = done1_r;
    assign req1_rdata  = rdata1_r;
    assign req1_resp   = resp1_r;
    assign busy        = busy_r;

endmodule
